// File: rtl/beep_driver_if.sv
// Request/tone signal bundle between the game control logic (master) and
// the buzzer driver (slave).
interface beep_driver_if;
   logic beep_req;
   logic buzz;
   logic busy;
   logic beep_drop;

   modport master (output beep_req, input buzz, busy, beep_drop);
   modport slave  (input beep_req, output buzz, busy, beep_drop);
endinterface

// File: rtl/beep_driver.sv
// Turns one-cycle beep requests into fixed-length square-wave bursts separated
// by a forced silent gap; up to three requests wait while a burst/gap runs.
module beep_driver #(
   parameter int unsigned BEEP_TIME = 5_000_000,
   parameter int unsigned GAP_TIME  = 2_500_000,
   parameter int unsigned TONE_HALF = 12_500
) (
   input  logic          clk,
   input  logic          rstn,
   beep_driver_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

   localparam logic [23:0] BEEP_LAST = 24'(BEEP_TIME - 1);
   localparam logic [23:0] GAP_LAST  = 24'(GAP_TIME - 1);
   localparam logic [23:0] TONE_LAST = 24'(TONE_HALF - 1);

   state_t      state;
   logic [1:0]  pend_cnt;
   logic [23:0] dur_cnt;
   logic [23:0] gap_cnt;
   logic [23:0] tone_cnt;
   logic        gap_end;
   logic        enqueue;

   // A request is queued whenever it arrives while busy, except on the final
   // gap cycle where it is taken directly (or offsets the one being consumed).
   always_comb begin
      gap_end = (state == GAP) && (gap_cnt == GAP_LAST);
      enqueue = bus.beep_req && (state != IDLE) && !gap_end;
   end

   // NOTE: all state lives in one clocked block with non-blocking updates and
   // an asynchronous clear, so buzz drops the instant rstn falls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         pend_cnt      <= 2'd0;
         dur_cnt       <= '0;
         gap_cnt       <= '0;
         tone_cnt      <= '0;
         bus.buzz      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.beep_drop <= 1'b0;
      end else begin
         bus.beep_drop <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.beep_req) begin
                  state    <= BEEP;
                  bus.buzz <= 1'b1;
                  bus.busy <= 1'b1;
                  dur_cnt  <= '0;
                  tone_cnt <= '0;
               end
            end

            BEEP: begin
               dur_cnt <= dur_cnt + 24'd1;
               if (dur_cnt == BEEP_LAST) begin
                  // Burst end wins over a tone toggle on the same edge.
                  state    <= GAP;
                  bus.buzz <= 1'b0;
                  gap_cnt  <= '0;
               end else if (tone_cnt == TONE_LAST) begin
                  tone_cnt <= '0;
                  bus.buzz <= ~bus.buzz;
               end else begin
                  tone_cnt <= tone_cnt + 24'd1;
               end
            end

            GAP: begin
               gap_cnt  <= gap_cnt + 24'd1;
               bus.buzz <= 1'b0;
               if (gap_end) begin
                  if (pend_cnt != 2'd0 || bus.beep_req) begin
                     state    <= BEEP;
                     bus.buzz <= 1'b1;
                     dur_cnt  <= '0;
                     tone_cnt <= '0;
                     // With a new request on this edge the queue nets out.
                     if (!bus.beep_req) pend_cnt <= pend_cnt - 2'd1;
                  end else begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               bus.buzz <= 1'b0;
               bus.busy <= 1'b0;
            end
         endcase

         if (enqueue) begin
            if (pend_cnt == 2'd3) bus.beep_drop <= 1'b1;
            else                  pend_cnt      <= pend_cnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_beep_driver.sv
// Bench for beep_driver: directed scenarios then random request traffic,
// compared every cycle against a timeline model of bursts and a request queue.
module tb_beep_driver;

   localparam int BT     = 8;
   localparam int GT     = 4;
   localparam int TH     = 2;
   localparam int PERIOD = BT + GT;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;
   int   edge_no = 0;
   int   drop_seen = 0;

   // Reference model: a burst is a timeline anchored at its start edge.
   int   m_active = 0;
   int   m_start  = 0;
   int   m_pend   = 0;
   int   m_drop   = 0;

   beep_driver_if bif ();

   beep_driver #(
      .BEEP_TIME (BT),
      .GAP_TIME  (GT),
      .TONE_HALF (TH)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_pend   = 0;
      m_drop   = 0;
   endtask

   task automatic model_edge(input bit r);
      m_drop = 0;
      if (m_active == 0) begin
         if (r) begin
            m_active = 1;
            m_start  = edge_no;
         end
      end else if (edge_no - m_start == PERIOD) begin
         if (m_pend > 0 || r) begin
            m_start = edge_no;
            if (!r) m_pend--;
         end else begin
            m_active = 0;
         end
      end else if (r) begin
         if (m_pend < 3) m_pend++;
         else            m_drop = 1;
      end
   endtask

   function automatic logic exp_buzz();
      int k;
      k = edge_no - m_start;
      return (m_active != 0) && (k < BT) && (((k / TH) % 2) == 0);
   endfunction

   task automatic compare_outputs();
      check("buzz",      32'(bif.buzz),      32'(exp_buzz()));
      check("busy",      32'(bif.busy),      32'(m_active != 0));
      check("beep_drop", 32'(bif.beep_drop), 32'(m_drop));
   endtask

   task automatic step(input bit r);
      bif.beep_req = r;
      @(posedge clk);
      edge_no++;
      model_edge(r);
      #1;
      compare_outputs();
      drop_seen += int'(bif.beep_drop);
      bif.beep_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic apply_reset(input int n);
      rstn = 1'b0;
      model_reset();
      #1;
      check("rst_buzz", 32'(bif.buzz), 32'd0);
      check("rst_busy", 32'(bif.busy), 32'd0);
      check("rst_drop", 32'(bif.beep_drop), 32'd0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         edge_no++;
         #1;
         check("rst_hold_buzz", 32'(bif.buzz), 32'd0);
         check("rst_hold_busy", 32'(bif.busy), 32'd0);
      end
      rstn = 1'b1;
   endtask

   initial begin
      int rate;
      bif.beep_req = 1'b0;
      rstn = 1'b0;

      // Reset values, then quiet for 50 cycles.
      apply_reset(3);
      idle(50);

      // Single request.
      idle(10);
      step(1'b1);
      idle(20);

      // Three queued requests two cycles apart.
      idle(5);
      step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      idle(45);

      // Overflow: five back-to-back requests, only the fifth is dropped.
      idle(5);
      drop_seen = 0;
      for (int i = 0; i < 5; i++) step(1'b1);
      idle(4 * PERIOD + 5);
      check("overflow_drop_count", 32'(drop_seen), 32'd1);

      // Request on the final gap cycle while one request is pending.
      idle(5);
      step(1'b1);
      step(1'b1);
      idle(PERIOD - 2);
      step(1'b1);
      idle(3 * PERIOD + 5);

      // Reset during burst cycle 3 with two requests queued.
      idle(5);
      step(1'b1); step(1'b1); step(1'b1); step(1'b0);
      apply_reset(2);
      idle(3 * PERIOD);

      // Random traffic with varying request density and one mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) rate = int'($urandom_range(2, 60));
         if (i == 1517) apply_reset(int'($urandom_range(1, 3)));
         step(($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0);
      end
      idle(5 * PERIOD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
